// File: rtl/fp_add_sub.sv
// Single-precision IEEE-754 adder/subtractor with one output register stage.
// Round to nearest even; zero/subnormal inputs are read as signed zero, tiny results flush to zero.
module fp_add_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] opd1,
  input  logic [31:0] opd2,
  input  logic        op,
  output logic [31:0] res,
  output logic        exp_overflow,
  output logic        exp_underflow,
  output logic        nan,
  output logic        zero
);

  logic        signA, signB, effSub;
  logic [7:0]  expA, expB;
  logic [22:0] fracA, fracB;
  logic        aNan, bNan, aInf, bInf, aZero, bZero;

  logic        aBigger, signBig;
  logic [7:0]  expBig, expSmall, expDiff;
  logic [23:0] mantBig, mantSmall;
  logic [49:0] wide;
  logic [26:0] alignBig, alignSmall, norm;
  logic [27:0] sum;
  logic [4:0]  lzc;
  logic        roundUp;
  logic [24:0] mantSum;
  logic [22:0] mantRound;
  logic signed [9:0] expNorm, expFinal;

  logic [31:0] resNext;
  logic        ovfNext, unfNext, nanNext;

  // Highest set bit wins because the loop walks upward; all-zero input yields 27.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i <= 26; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  assign signA  = opd1[31];
  assign signB  = opd2[31] ^ op;
  assign effSub = signA ^ signB;
  assign expA   = opd1[30:23];
  assign expB   = opd2[30:23];
  assign fracA  = opd1[22:0];
  assign fracB  = opd2[22:0];
  assign aNan   = (expA == 8'hFF) && (fracA != 23'd0);
  assign bNan   = (expB == 8'hFF) && (fracB != 23'd0);
  assign aInf   = (expA == 8'hFF) && (fracA == 23'd0);
  assign bInf   = (expB == 8'hFF) && (fracB == 23'd0);
  assign aZero  = (expA == 8'd0);
  assign bZero  = (expB == 8'd0);

  always_comb begin
    aBigger   = opd1[30:0] >= opd2[30:0];
    signBig   = aBigger ? signA : signB;
    expBig    = aBigger ? expA : expB;
    expSmall  = aBigger ? expB : expA;
    mantBig   = aBigger ? {1'b1, fracA} : {1'b1, fracB};
    mantSmall = aBigger ? {1'b1, fracB} : {1'b1, fracA};
    expDiff   = expBig - expSmall;

    // Below 26 the wide shift loses nothing, so its low half folds exactly into sticky.
    wide = {mantSmall, 26'd0} >> expDiff;
    if (expDiff >= 8'd26)
      alignSmall = 27'd1;
    else
      alignSmall = {wide[49:24], |wide[23:0]};
    alignBig = {mantBig, 3'b000};

    sum = effSub ? ({1'b0, alignBig} - {1'b0, alignSmall})
                 : ({1'b0, alignBig} + {1'b0, alignSmall});
    lzc = lzc27(sum[26:0]);

    if (sum[27]) begin
      norm    = {sum[27:2], sum[1] | sum[0]};
      expNorm = $signed({2'b00, expBig}) + 10'sd1;
    end else begin
      norm    = sum[26:0] << lzc;
      expNorm = $signed({2'b00, expBig}) - $signed({5'd0, lzc});
    end

    roundUp = norm[2] & (norm[1] | norm[0] | norm[3]);
    mantSum = {1'b0, norm[26:3]} + {24'd0, roundUp};
    if (mantSum[24]) begin
      mantRound = mantSum[23:1];
      expFinal  = expNorm + 10'sd1;
    end else begin
      mantRound = mantSum[22:0];
      expFinal  = expNorm;
    end

    resNext = 32'd0;
    ovfNext = 1'b0;
    unfNext = 1'b0;
    nanNext = 1'b0;
    if (aNan || bNan || (aInf && bInf && effSub)) begin
      resNext = 32'h7FC00000;
      nanNext = 1'b1;
    end else if (aInf) begin
      resNext = {signA, 8'hFF, 23'd0};
    end else if (bInf) begin
      resNext = {signB, 8'hFF, 23'd0};
    end else if (aZero && bZero) begin
      resNext = {signA & signB, 31'd0};
    end else if (aZero) begin
      resNext = {signB, opd2[30:0]};
    end else if (bZero) begin
      resNext = opd1;
    end else if (sum == 28'd0) begin
      resNext = 32'd0;
    end else if (expFinal >= 10'sd255) begin
      resNext = {signBig, 8'hFF, 23'd0};
      ovfNext = 1'b1;
    end else if (expFinal <= 10'sd0) begin
      resNext = {signBig, 31'd0};
      unfNext = 1'b1;
    end else begin
      resNext = {signBig, expFinal[7:0], mantRound};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res           <= 32'd0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
      nan           <= 1'b0;
      zero          <= 1'b0;
    end else begin
      res           <= resNext;
      exp_overflow  <= ovfNext;
      exp_underflow <= unfNext;
      nan           <= nanNext;
      zero          <= (resNext[30:0] == 31'd0);
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Scoreboard bench for fp_add_sub: expected results come from a real-arithmetic
// reference with zero/subnormal-in and flush-to-zero-out rules.
module tb_fp_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] opd1 = 32'd0;
  logic [31:0] opd2 = 32'd0;
  logic        op = 1'b0;
  logic [31:0] res;
  logic        exp_overflow, exp_underflow, nan, zero;

  int checks = 0;
  int passes = 0;
  logic stimValid = 1'b0;
  logic pendingCheck = 1'b0;
  logic [35:0] expQ[$];
  string tagQ[$];

  fp_add_sub dut (
    .clk(clk),
    .rst(rst),
    .opd1(opd1),
    .opd2(opd2),
    .op(op),
    .res(res),
    .exp_overflow(exp_overflow),
    .exp_underflow(exp_underflow),
    .nan(nan),
    .zero(zero)
  );

  always #5 clk = ~clk;

  // Flags are packed as {overflow, underflow, nan, zero} below the result word.
  task automatic checkOutput(input string tag, input logic [35:0] actual, input logic [35:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s: got res=%h flags(ovf,unf,nan,zero)=%b, expected res=%h flags=%b",
               tag, actual[35:4], actual[3:0], expected[35:4], expected[3:0]);
  endtask

  function automatic real toReal(input logic s, input logic [7:0] e, input logic [22:0] f);
    logic [10:0] de;
    de = 11'(int'(e) - 127 + 1023);
    return $bitstoreal({s, de, f, 29'd0});
  endfunction

  function automatic logic [35:0] refModel(input logic [31:0] a, input logic [31:0] b, input logic o);
    logic sa, sb, g, st;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic [63:0] bits;
    logic [24:0] m;
    real r;
    int e;
    sa = a[31]; sb = b[31] ^ o;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 8'hFF && fa != 0) || (eb == 8'hFF && fb != 0)) return {32'h7FC00000, 4'b0010};
    if (ea == 8'hFF && eb == 8'hFF && sa != sb) return {32'h7FC00000, 4'b0010};
    if (ea == 8'hFF) return {sa, 8'hFF, 23'd0, 4'b0000};
    if (eb == 8'hFF) return {sb, 8'hFF, 23'd0, 4'b0000};
    if (ea == 0 && eb == 0) return {sa & sb, 31'd0, 4'b0001};
    if (ea == 0) return {sb, b[30:0], 4'b0000};
    if (eb == 0) return {a, 4'b0000};
    // A double holds the float sum precisely enough that rounding it again to 24 bits is exact RNE.
    r = toReal(sa, ea, fa) + toReal(sb, eb, fb);
    if (r == 0.0) return {32'd0, 4'b0001};
    bits = $realtobits(r);
    e = int'(bits[62:52]) - 1023 + 127;
    m = {2'b01, bits[51:29]};
    g = bits[28];
    st = |bits[27:0];
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e++;
    end
    if (e >= 255) return {bits[63], 8'hFF, 23'd0, 4'b1000};
    if (e <= 0) return {bits[63], 31'd0, 4'b0101};
    return {bits[63], 8'(e), m[22:0], 4'b0000};
  endfunction

  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o);
    @(negedge clk);
    rst = 1'b0;
    opd1 = a;
    opd2 = b;
    op = o;
    stimValid = 1'b1;
    expQ.push_back(refModel(a, b, o));
    tagQ.push_back(tag);
  endtask

  function automatic logic [31:0] randOperand();
    logic [7:0] e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 15);
    f = 23'($urandom);
    if (k == 0) e = 8'd0;
    else if (k == 1) begin
      e = 8'hFF;
      if ($urandom_range(0, 1) == 0) f = 23'd0;
    end
    else if (k == 2) e = 8'($urandom_range(250, 254));
    else if (k == 3) e = 8'($urandom_range(1, 4));
    else e = 8'($urandom_range(1, 254));
    return {1'($urandom), e, f};
  endfunction

  always @(posedge clk) pendingCheck <= stimValid && !rst;

  always @(negedge clk) begin
    if (pendingCheck) begin
      if (expQ.size() == 0)
        checkOutput("underrun", {res, exp_overflow, exp_underflow, nan, zero}, 36'hFFFFFFFFF);
      else
        checkOutput(tagQ.pop_front(), {res, exp_overflow, exp_underflow, nan, zero}, expQ.pop_front());
    end
  end

  initial begin
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    checkOutput("reset", {res, exp_overflow, exp_underflow, nan, zero}, 36'd0);

    applyStimulus("add1p1", 32'h3F800000, 32'h3F800000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    stimValid = 1'b0;
    opd1 = 32'h7F7FFFFF;
    opd2 = 32'h7F7FFFFF;
    @(negedge clk);
    checkOutput("resetMid", {res, exp_overflow, exp_underflow, nan, zero}, 36'd0);
    if (expQ.size() != 0)
      $display("[TB] scoreboard not empty after reset: %0d", expQ.size());

    applyStimulus("sub3m1", 32'h40400000, 32'h3F800000, 1'b1);
    applyStimulus("cancel", 32'h3F800000, 32'h3F800000, 1'b1);
    applyStimulus("tieEven", 32'h3F800000, 32'h33800000, 1'b0);
    applyStimulus("tieOddUp", 32'h3F800001, 32'h33800000, 1'b0);
    applyStimulus("aboveHalf", 32'h3F800000, 32'h33800001, 1'b0);
    applyStimulus("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    applyStimulus("infPlus1", 32'h7F800000, 32'h3F800000, 1'b0);
    applyStimulus("infMinusInf", 32'h7F800000, 32'h7F800000, 1'b1);
    applyStimulus("nanIn", 32'h7FC00001, 32'h3F800000, 1'b0);
    applyStimulus("underflow", 32'h00800001, 32'h00800000, 1'b1);
    applyStimulus("dazPlus1", 32'h00000001, 32'h3F800000, 1'b0);
    applyStimulus("negZeros", 32'h80000000, 32'h00000000, 1'b1);
    applyStimulus("zeroMinusX", 32'h00000000, 32'h40490FDB, 1'b1);
    applyStimulus("farShift", 32'h4B000000, 32'h3F7FFFFF, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      a = randOperand();
      b = randOperand();
      if ($urandom_range(0, 1) == 1) begin
        b = a ^ {1'($urandom), 8'd0, 23'($urandom_range(0, 255))};
        if ($urandom_range(0, 1) == 1 && a[30:23] > 8'd1 && a[30:23] < 8'd254)
          b[30:23] = ($urandom_range(0, 1) == 1) ? a[30:23] + 8'd1 : a[30:23] - 8'd1;
      end
      applyStimulus("random", a, b, 1'($urandom));
    end

    @(negedge clk);
    stimValid = 1'b0;
    for (int w = 0; w < 8 && expQ.size() != 0; w++) @(negedge clk);
    checkOutput("drain", 36'(expQ.size()), 36'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fp_add_sub.md
Name: fp_add_sub

Overview:
- Single-precision IEEE-754 adder/subtractor with registered outputs.
- Computes opd1 + opd2 (op=0) or opd1 - opd2 (op=1).
- Rounds to nearest, ties to even; flushes subnormals to zero.
- Reports overflow, underflow, NaN and zero status alongside the result. Used as the add/sub lane of the FPU datapath.

Parameters:
- None. The format is fixed at binary32: 1 sign bit, 8 exponent bits (bias 127), 23 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- opd1  input  32  operand A, binary32
- opd2  input  32  operand B, binary32
- op  input  1  0 = add, 1 = subtract (sign of opd2 inverted)
- res  output  32  binary32 result, registered
- exp_overflow  output  1  result exponent exceeded 254; res forced to ±inf
- exp_underflow  output  1  nonzero exact result below min normal (2^-126); res flushed to ±0
- nan  output  1  res is NaN
- zero  output  1  res is ±0

Behaviour:
- Reset: one clock is used; reset is synchronous and active-high. While rst=1 at a clk rising edge, res=0x00000000 and all four flags are 0. Reset overrides any in-flight operation; inputs sampled in that cycle are discarded.
- Latency and throughput:
  - Datapath is fully combinational from opd1/opd2/op to a single output register stage.
  - Inputs sampled at rising edge N appear on res/flags after edge N. Latency 1 cycle, throughput 1 per cycle, no handshake.
- Operand classification:
  - exp=0 (zero or subnormal) is treated as signed zero (DAZ).
  - exp=255, frac=0 is ±inf.
  - exp=255, frac≠0 is NaN.
- Effective operation: sign_b_eff = opd2[31] XOR op.
- Special cases, in priority order:
  1. Either input NaN → res=0x7FC00000, nan=1.
  2. inf + (-inf) after effective sign → 0x7FC00000, nan=1.
  3. Any inf → that inf, all flags 0.
  4. Both zero → signed zero; sign is negative only if both effective signs are negative. zero=1.
  5. One zero → the other operand unchanged.
- Normal path:
  - Restore hidden bits and swap so the larger magnitude is first.
  - Right-shift the smaller mantissa by the exponent difference, keeping guard, round and sticky bits. A shift ≥ 26 collapses the operand into sticky.
  - Add or subtract the 24-bit mantissas using a 25-bit datapath plus GRS.
  - Normalize: carry-out → shift right 1, exp+1. Otherwise leading-zero count → shift left, exp-lzc.
  - Round to nearest, ties to even. A rounding carry into bit 24 renormalizes (exp+1).
  - Result sign is the sign of the larger-magnitude operand.
- Exact cancellation: res=+0x00000000, zero=1.
- Overflow: final exp ≥ 255 → res = sign|0x7F800000, exp_overflow=1.
- Underflow: final exp ≤ 0 with nonzero magnitude → res = sign|0x00000000, exp_underflow=1, zero=1.
- Flag exclusivity: nan and exp_overflow are never both 1. zero=1 whenever res[30:0]=0.
- Back-to-back inputs are independent; there is no state other than the output register.

Test Plan:
- Add and reset: opd1=0x3F800000, opd2=0x3F800000, op=0 → res=0x40000000 (2.0), flags 0. Next cycle assert rst → res=0, flags 0.
- Subtraction and cancellation:
  - 0x40400000 - 0x3F800000, op=1 → 0x40000000.
  - 0x3F800000 - 0x3F800000, op=1 → 0x00000000, zero=1.
- Rounding, ties to even:
  - 0x3F800000 + 0x33800000 → 0x3F800000.
  - 0x3F800001 + 0x33800000 → 0x3F800002.
  - 0x3F800000 + 0x33800001 → 0x3F800001.
- Overflow and inf:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, exp_overflow=1.
  - 0x7F800000 + 0x3F800000 → 0x7F800000, flags 0.
- NaN:
  - 0x7F800000 - 0x7F800000, op=1 → 0x7FC00000, nan=1.
  - 0x7FC00001 + 0x3F800000 → 0x7FC00000, nan=1.
- Underflow and DAZ:
  - 0x00800001 - 0x00800000, op=1 → 0x00000000, exp_underflow=1, zero=1.
  - 0x00000001 + 0x3F800000 → 0x3F800000.
- Random regression: 10k vectors compared against a reference model with DAZ/FTZ.
